// File: rtl/pic_pkg.sv
// ============================================================================
// Module      : pic_pkg
// Description : Shared types and opcode-class constants for the PIC10F200
//               instruction-cycle sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pic_pkg;

    typedef enum logic [1:0] {
        Q1 = 2'd0,
        Q2 = 2'd1,
        Q3 = 2'd2,
        Q4 = 2'd3
    } q_phase_t;

    typedef enum logic [1:0] {
        S_FETCH0 = 2'd0,
        S_EXEC   = 2'd1,
        S_FLUSH  = 2'd2,
        S_SLEEP  = 2'd3
    } ctrl_state_t;

    localparam logic [4:0]  INDF_ADDR   = 5'd0;

    // Major opcode groups, ir[11:10]
    localparam logic [1:0]  GRP_BYTE    = 2'b00;
    localparam logic [1:0]  GRP_BIT     = 2'b01;
    localparam logic [1:0]  GRP_CTRL    = 2'b10;
    localparam logic [1:0]  GRP_LIT     = 2'b11;

    // Byte-oriented opcodes, ir[9:6]
    localparam logic [3:0]  OP_DECFSZ   = 4'b1011;
    localparam logic [3:0]  OP_INCFSZ   = 4'b1111;

    // Bit-oriented opcodes, ir[9:8]
    localparam logic [1:0]  BOP_BTFSC   = 2'b10;
    localparam logic [1:0]  BOP_BTFSS   = 2'b11;

    // Control-transfer opcodes, ir[9:8]; GOTO occupies 2'b1x
    localparam logic [1:0]  COP_RETLW   = 2'b00;
    localparam logic [1:0]  COP_CALL    = 2'b01;

    // Upper seven bits identifying the misc and CLRW rows of the byte group
    localparam logic [6:0]  MISC_ROW    = 7'b0000000;
    localparam logic [6:0]  CLRW_ROW    = 7'b0000010;

    localparam logic [11:0] CLRW_WORD   = 12'h040;
    localparam logic [11:0] SLEEP_WORD  = 12'h003;

    // Skip decision from the decoded class and the ALU zero/bit-test result.
    function automatic logic skip_taken(
        input logic skip_zero,
        input logic btfsc,
        input logic btfss,
        input logic cond
    );
        return (skip_zero & cond) | (btfsc & cond) | (btfss & ~cond);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pic_cycle_ctrl_decode.sv
// ============================================================================
// Module      : pic_decode
// Description : Combinational instruction classifier for the cycle sequencer.
//               SLEEP is recognised only when PIC_SLEEP_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pic_decode
    import pic_pkg::*;
#(
    parameter int IR_W = 12,
    parameter int FA_W = 5
) (
    input  logic [IR_W-1:0] ir,
    output logic            is_file_ref,
    output logic            wr_file,
    output logic            wr_w,
    output logic            is_branch,
    output logic            is_skip_zero,
    output logic            is_btfsc,
    output logic            is_btfss,
    output logic            is_call,
    output logic            is_retlw,
    output logic            is_sleep
);

    logic [1:0] w_grp;
    logic       w_misc_row;
    logic       w_clrw_row;
    logic       w_byte_op;
    logic       w_bit_op;
    logic       w_ctrl_op;
    logic       w_lit_op;
    logic       w_dest_f;

    assign w_grp      = ir[11:10];
    assign w_misc_row = (ir[11:FA_W] == MISC_ROW);
    assign w_clrw_row = (ir[11:FA_W] == CLRW_ROW);
    assign w_dest_f   = ir[FA_W];

    // The misc and CLRW rows share the byte-op group but touch no file register.
    assign w_byte_op  = (w_grp == GRP_BYTE) && !w_misc_row && !w_clrw_row;
    assign w_bit_op   = (w_grp == GRP_BIT);
    assign w_ctrl_op  = (w_grp == GRP_CTRL);
    assign w_lit_op   = (w_grp == GRP_LIT);

    always_comb begin
        is_file_ref  = w_byte_op | w_bit_op;
        wr_file      = (w_byte_op & w_dest_f) | (w_bit_op & ~ir[9]);
        is_retlw     = w_ctrl_op & (ir[9:8] == COP_RETLW);
        is_call      = w_ctrl_op & (ir[9:8] == COP_CALL);
        is_branch    = w_ctrl_op;
        wr_w         = (w_byte_op & ~w_dest_f) | (ir == CLRW_WORD) | w_lit_op | is_retlw;
        is_skip_zero = w_byte_op & ((ir[9:6] == OP_DECFSZ) | (ir[9:6] == OP_INCFSZ));
        is_btfsc     = w_bit_op & (ir[9:8] == BOP_BTFSC);
        is_btfss     = w_bit_op & (ir[9:8] == BOP_BTFSS);
`ifdef PIC_SLEEP_EN
        is_sleep     = (ir == SLEEP_WORD);
`else
        is_sleep     = 1'b0;
`endif
    end

endmodule

`default_nettype wire

// File: rtl/pic_cycle_ctrl.sv
// ============================================================================
// Module      : pic_cycle_ctrl
// Description : PIC10F200 Q1..Q4 instruction-cycle sequencer with flush-cycle
//               insertion. Optional sleep support under PIC_SLEEP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pic_cycle_ctrl
    import pic_pkg::*;
#(
    parameter int IR_W = 12,
    parameter int FA_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IR_W-1:0] ir,
    input  logic            skip_cond,
`ifdef PIC_SLEEP_EN
    input  logic            wake,
`endif
    output logic [1:0]      q_phase,
    output logic            addr_mux_sel,
    output logic            rf_rd_en,
    output logic            rf_wr_en,
    output logic            w_wr_en,
    output logic            pc_inc,
    output logic            pc_load,
    output logic            stack_push,
    output logic            stack_pop,
    output logic            ir_load,
    output logic            flush
);

    logic [1:0]  r_q;
    ctrl_state_t r_state;
    ctrl_state_t w_next_state;
    logic        r_skip;

    logic        w_is_file_ref;
    logic        w_wr_file;
    logic        w_wr_w;
    logic        w_is_branch;
    logic        w_is_skip_zero;
    logic        w_is_btfsc;
    logic        w_is_btfss;
    logic        w_is_call;
    logic        w_is_retlw;
    logic        w_is_sleep;

    logic        w_active;
    logic        w_exec;
    logic        w_at_q2;
    logic        w_at_q4;

    pic_decode #(
        .IR_W (IR_W),
        .FA_W (FA_W)
    ) u_decode (
        .ir           (ir),
        .is_file_ref  (w_is_file_ref),
        .wr_file      (w_wr_file),
        .wr_w         (w_wr_w),
        .is_branch    (w_is_branch),
        .is_skip_zero (w_is_skip_zero),
        .is_btfsc     (w_is_btfsc),
        .is_btfss     (w_is_btfss),
        .is_call      (w_is_call),
        .is_retlw     (w_is_retlw),
        .is_sleep     (w_is_sleep)
    );

    always_comb begin
        w_next_state = S_EXEC;
        case (r_state)
            S_EXEC: begin
                if (w_is_sleep)
                    w_next_state = S_SLEEP;
                else if (w_is_branch || r_skip)
                    w_next_state = S_FLUSH;
                else
                    w_next_state = S_EXEC;
            end
            default: w_next_state = S_EXEC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q     <= Q1;
            r_state <= S_FETCH0;
            r_skip  <= 1'b0;
        end else begin
            if (r_state == S_SLEEP)
                r_q <= Q1;
            else
                r_q <= r_q + 2'd1;

            // Skip decision is captured on the edge that ends Q3.
            if (r_q == Q3)
                r_skip <= (r_state == S_EXEC) &&
                          skip_taken(w_is_skip_zero, w_is_btfsc, w_is_btfss, skip_cond);

            case (r_state)
                S_SLEEP: begin
`ifdef PIC_SLEEP_EN
                    if (wake)
                        r_state <= S_FLUSH;
`else
                    r_state <= S_FETCH0;
`endif
                end
                default: begin
                    if (r_q == Q4)
                        r_state <= w_next_state;
                end
            endcase
        end
    end

    // Gating with rst aborts the cycle in whatever phase reset arrives.
    assign w_active = ~rst;
    assign w_exec   = w_active && (r_state == S_EXEC);
    assign w_at_q2  = (r_q == Q2);
    assign w_at_q4  = (r_q == Q4);

    always_comb begin
        q_phase      = r_q;
        addr_mux_sel = ~(w_exec && w_is_file_ref && (ir[FA_W-1:0] == INDF_ADDR));
        rf_rd_en     = w_exec && w_at_q2 && w_is_file_ref;
        rf_wr_en     = w_exec && w_at_q4 && w_wr_file;
        w_wr_en      = w_exec && w_at_q4 && w_wr_w;
        pc_load      = w_exec && w_at_q4 && w_is_branch;
        stack_push   = w_exec && w_at_q4 && w_is_branch && w_is_call;
        stack_pop    = w_exec && w_at_q4 && w_is_branch && w_is_retlw;
        pc_inc       = w_active && w_at_q4 &&
                       ((r_state == S_FETCH0) || (r_state == S_FLUSH) ||
                        ((r_state == S_EXEC) && !w_is_branch));
        ir_load      = w_active && w_at_q4 && (r_state != S_SLEEP);
        flush        = w_active && (r_state == S_FLUSH);
    end

endmodule

`default_nettype wire

// File: tb/tb_pic_cycle_ctrl.sv
// ============================================================================
// Module      : tb_pic_cycle_ctrl
// Description : Scoreboard bench for pic_cycle_ctrl with directed instruction
//               cycles and hand-computed per-cycle strobe patterns.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pic_cycle_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] ir = 12'h000;
    logic        skip_cond = 1'b0;
`ifdef PIC_SLEEP_EN
    logic        wake = 1'b0;
`endif
    logic [1:0]  q_phase;
    logic        addr_mux_sel, rf_rd_en, rf_wr_en, w_wr_en, pc_inc, pc_load;
    logic        stack_push, stack_pop, ir_load, flush;

    pic_cycle_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .ir           (ir),
        .skip_cond    (skip_cond),
`ifdef PIC_SLEEP_EN
        .wake         (wake),
`endif
        .q_phase      (q_phase),
        .addr_mux_sel (addr_mux_sel),
        .rf_rd_en     (rf_rd_en),
        .rf_wr_en     (rf_wr_en),
        .w_wr_en      (w_wr_en),
        .pc_inc       (pc_inc),
        .pc_load      (pc_load),
        .stack_push   (stack_push),
        .stack_pop    (stack_pop),
        .ir_load      (ir_load),
        .flush        (flush)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [47:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic mon_en = 1'b1;
    logic rst_d  = 1'b0;

    // Per-phase sample: {q_phase, mux, rd, wr, w, inc, load, push, pop, ir_load, flush}
    logic [11:0] sample;
    assign sample = {q_phase, addr_mux_sel, rf_rd_en, rf_wr_en, w_wr_en, pc_inc,
                     pc_load, stack_push, stack_pop, ir_load, flush};

    localparam logic [11:0] RST_VAL = {2'd0, 1'b1, 9'd0};

    // Expands a one-line cycle description into the four expected phase samples.
    function automatic logic [47:0] cyc(input logic mux, input logic rd, input logic wr,
                                        input logic w, input logic inc, input logic load,
                                        input logic push, input logic pop, input logic fl);
        logic [47:0] r;
        logic [1:0]  pp;
        logic        last;
        r = '0;
        for (int p = 0; p < 4; p++) begin
            pp   = 2'(p);
            last = (p == 3);
            r[p*12 +: 12] = {pp, mux, rd & (p == 1), wr & last, w & last, inc & last,
                             load & last, push & last, pop & last, last, fl};
        end
        return r;
    endfunction

    always @(posedge clk) rst_d <= rst;

    // Monitor: collects one instruction cycle and checks it against the scoreboard.
    initial begin
        logic [47:0] acc;
        int          pos;
        exp_t        e;
        acc = '0;
        pos = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pos = 0;
                acc = '0;
                if (rst_d) begin
                    checks++;
                    if (sample !== RST_VAL) begin
                        errors++;
                        $display("FAIL reset_state: got %h required %h", sample, RST_VAL);
                    end
                end
            end else if (mon_en) begin
                acc[pos*12 +: 12] = sample;
                pos++;
                if (pos == 4) begin
                    pos = 0;
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_cycle: got %h required none", acc);
                    end else begin
                        e = sb.pop_front();
                        if (acc !== e.exp) begin
                            errors++;
                            $display("FAIL %s: got %h required %h", e.name, acc, e.exp);
                        end
                    end
                end
            end
        end
    end

    task automatic run(input string name, input logic [11:0] iw, input logic sk,
                       input logic [47:0] exp);
        exp_t e;
        ir        = iw;
        skip_cond = sk;
        e.name    = name;
        e.exp     = exp;
        sb.push_back(e);
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    //                                   mux rd wr w  inc ld ps pp fl
    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        run("fetch0",        12'h000, 1'b0, cyc(1, 0, 0, 0, 1, 0, 0, 0, 0));
        run("addwf_indf",    12'h1E0, 1'b0, cyc(0, 1, 1, 0, 1, 0, 0, 0, 0));
        run("addwf_direct",  12'h1E7, 1'b0, cyc(1, 1, 1, 0, 1, 0, 0, 0, 0));
        run("movlw",         12'hC55, 1'b1, cyc(1, 0, 0, 1, 1, 0, 0, 0, 0));
        run("goto",          12'hA10, 1'b0, cyc(1, 0, 0, 0, 0, 1, 0, 0, 0));
        run("goto_flush",    12'h1E0, 1'b1, cyc(1, 0, 0, 0, 1, 0, 0, 0, 1));
        run("call",          12'h920, 1'b0, cyc(1, 0, 0, 0, 0, 1, 1, 0, 0));
        run("call_flush_br", 12'h8AA, 1'b0, cyc(1, 0, 0, 0, 1, 0, 0, 0, 1));
        run("btfss_taken",   12'h706, 1'b0, cyc(1, 1, 0, 0, 1, 0, 0, 0, 0));
        run("btfss_flush",   12'h1E0, 1'b0, cyc(1, 0, 0, 0, 1, 0, 0, 0, 1));
        run("decfsz_nskip",  12'h2E5, 1'b0, cyc(1, 1, 1, 0, 1, 0, 0, 0, 0));
        run("btfsc_nskip",   12'h600, 1'b0, cyc(0, 1, 0, 0, 1, 0, 0, 0, 0));
        run("retlw",         12'h8AA, 1'b0, cyc(1, 0, 0, 1, 0, 1, 0, 1, 0));
        run("retlw_flush",   12'h000, 1'b0, cyc(1, 0, 0, 0, 1, 0, 0, 0, 1));
        run("incfsz_taken",  12'h3C0, 1'b1, cyc(0, 1, 0, 1, 1, 0, 0, 0, 0));
        run("incfsz_flush",  12'hC55, 1'b1, cyc(1, 0, 0, 0, 1, 0, 0, 0, 1));
        run("nop",           12'h000, 1'b1, cyc(1, 0, 0, 0, 1, 0, 0, 0, 0));
        run("sleep_as_nop",  12'h003, 1'b0, cyc(1, 0, 0, 0, 1, 0, 0, 0, 0));
        run("clrw",          12'h040, 1'b0, cyc(1, 0, 0, 1, 1, 0, 0, 0, 0));
        run("movwf_indf",    12'h020, 1'b0, cyc(0, 1, 1, 0, 1, 0, 0, 0, 0));
        run("bsf_indf",      12'h5E0, 1'b0, cyc(0, 1, 1, 0, 1, 0, 0, 0, 0));
        run("btfsc_taken",   12'h600, 1'b1, cyc(0, 1, 0, 0, 1, 0, 0, 0, 0));
        run("btfsc_flush",   12'h1E7, 1'b0, cyc(1, 0, 0, 0, 1, 0, 0, 0, 1));

        // Reset arrives in Q3 of an indirect ADDWF and is held for three clocks.
        ir = 12'h1E0;
        skip_cond = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        run("refetch0",      12'h1E0, 1'b0, cyc(1, 0, 0, 0, 1, 0, 0, 0, 0));
        run("addwf_after",   12'h1E0, 1'b0, cyc(0, 1, 1, 0, 1, 0, 0, 0, 0));

        mon_en = 1'b0;
        repeat (2) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
